qc_link_master: RTL and testbench
=================================

# qc_link_master

Hardware host for the quantum-emulator load/readout handshake. It stands in for the soft processor on the GPIO side of the gate/state FSM. It consumes a framed byte stream (header, state vector, one or more gate matrices) and drives it onto `load_temp`/`load_ready`/`new_gate` using the two-phase level handshake. Once the last gate is loaded, it runs the readout phase, samples `send_temp`, and returns the resulting state as a byte stream.

## Interface
- `N`, 2: qubit count; `MAX = 2**N` amplitudes, gate is MAX×MAX.
- `HOLD`, 4: cycles each `load_ready` level is held before the next phase (≥3).
- `SETTLE`, 8: idle cycles between the last gate load and the first readout phase.
- `clk` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `rx_data` in 8: inbound frame byte.
- `rx_valid` in 1: `rx_data` valid.
- `rx_ready` out 1: byte accepted when `rx_valid & rx_ready`.
- `tx_data` out 8: outbound result byte.
- `tx_valid` out 1: `tx_data` valid.
- `tx_ready` in 1: sink accepts when `tx_valid & tx_ready`.
- `load_temp` out 8: data to partner FSM.
- `load_ready` out 1: phase strobe. Rising edge = real byte / read real; falling edge = imag byte / read imag.
- `new_gate` out 8: bit0 = another gate follows the current one; bits 7:1 = 0.
- `send_temp` in 8: readout byte from partner FSM.
- `busy` out 1: high from header accept until the last tx byte is accepted.

## Operation
- Frame: header G (gate count, 0 treated as 1), then MAX (real, imag) byte pairs of state, then G blocks of MAX·MAX (real, imag) pairs in row-major order. Components are signed 8-bit, passed through unmodified.
- States:
  - IDLE: `rx_ready`=1. Header accepted → LD_RE, gates_left=G, pair=0, phase=STATE.
  - LD_RE: wait for a byte; then `load_temp`←byte, `load_ready`←1 in the same cycle. Go to HOLD_HI.
  - HOLD_HI: count HOLD cycles → LD_IM.
  - LD_IM: wait for a byte; then `load_temp`←byte, `load_ready`←0 in the same cycle. Go to HOLD_LO.
  - HOLD_LO: count HOLD, then advance pair. State done (pair==MAX-1) → phase=GATE, pair=0. Gate done (pair==MAX·MAX-1) → gates_left-1; if it reaches 0 go to SETTLE, else stay in GATE with pair=0. Otherwise → LD_RE.
  - SETTLE: SETTLE cycles → RD_HI, pair=0.
  - RD_HI: `load_ready`←1, hold HOLD, capture `send_temp` into `tx_data`, `tx_valid`←1 → EMIT_RE.
  - EMIT_RE: hold `load_ready`=1 until tx accept → RD_LO.
  - RD_LO: `load_ready`←0, hold HOLD, capture → EMIT_IM.
  - EMIT_IM: on accept, pair==MAX-1 → IDLE (or CKSUM, see Configuration); else → RD_HI.
- `new_gate[0]` ← (gates_left > 1) when the first real byte of each gate is driven. It is held stable through that gate's last falling phase and cleared in IDLE.
- `rx_ready` is high only in IDLE, LD_RE and LD_IM. A stall in rx or tx holds the current `load_ready` level, so the partner simply waits.
- Counters: pair is 2N bits; gates_left is 8 bits.

## Timing
- Reset values: `load_temp`=0, `load_ready`=0, `new_gate`=0, `rx_ready`=0 on the reset cycle (1 from the next cycle in IDLE), `tx_valid`=0, `tx_data`=0, `busy`=0. The FSM returns to IDLE.
- Reset mid-frame aborts the transfer and discards the partial frame. The partner shares `reset` and restarts in step.
- `load_temp` and the `load_ready` edge change in the same clock. `load_temp` is held stable until the next edge.
- Minimum per load pair: 2 + 2·HOLD cycles with rx always valid.
- `send_temp` is sampled on the HOLD-th cycle after the edge. The partner updates it 1 cycle after seeing the edge, so HOLD ≥ 3 is required.
- `tx_valid` stays high with `tx_data` stable until accepted.
- `busy` falls in the cycle after the final tx accept.

## Configuration
- `QC_LINK_CHECKSUM_EN`
  - Defined: after the last readout byte, a CKSUM state emits one extra tx byte equal to the XOR of all 2·MAX readout bytes, then returns to IDLE. Total tx = 2·MAX+1.
  - Undefined: no CKSUM state; exactly 2·MAX tx bytes per frame.

## Test plan
- N=2, G=1, state (1,0),(0,0),(0,0),(0,0), identity gate (41 rx bytes), bench partner-FSM model → tx 01,00,00,00,00,00,00,00; `new_gate[0]`=0 throughout.
- G=2, both gates X⊗I (rows permute 0↔2, 1↔3), state (5,1) at index 0 → `new_gate[0]`=1 during gate 1, 0 during gate 2; result (5,1) at index 0.
- Random rx gaps of 0–10 cycles and `tx_ready` low for 20 cycles mid-readout → identical output bytes; `load_ready` never toggles while a byte is missing.
- Reset asserted during gate pair 7, then a fresh G=1 frame → all outputs at reset values the next cycle; second frame completes correctly.
- Header 0 → treated as one gate; 8 tx bytes returned.
- With `QC_LINK_CHECKSUM_EN`, readout 10,20,30,40,00,00,00,00 → ninth tx byte 0x28.

Source files
------------

// File: rtl/qc_link_master.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : qc_link_master                                           |
// | Description : Hardware host for the quantum-emulator load/readout      |
// |               handshake. Consumes a framed byte stream (header G,      |
// |               MAX state pairs, G gate blocks of MAX*MAX pairs), drives  |
// |               it onto load_temp/load_ready/new_gate with the two-phase |
// |               level handshake, then runs the readout phase on          |
// |               send_temp and returns 2*MAX result bytes on tx.          |
// | Option      : QC_LINK_CHECKSUM_EN - append one XOR checksum byte       |
// |               after the readout bytes.                                 |
// | Ports       : clk, reset         - clock, sync active-high reset       |
// |               rx_data/valid/ready - inbound frame byte stream          |
// |               tx_data/valid/ready - outbound result byte stream        |
// |               load_temp, load_ready, new_gate - to partner FSM         |
// |               send_temp          - readout byte from partner FSM       |
// |               busy               - frame in progress                   |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module qc_link_master #(
  parameter int N      = 2,
  parameter int HOLD   = 4,
  parameter int SETTLE = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_ready,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic [7:0] load_temp,
  output logic       load_ready,
  output logic [7:0] new_gate,
  input  logic [7:0] send_temp,
  output logic       busy
);

  localparam int MAX = 2**N;
  localparam int PW  = 2*N;
  localparam int CW  = 16;

  localparam logic [PW-1:0] c_pair_state_last = PW'(MAX-1);
  localparam logic [PW-1:0] c_pair_gate_last  = PW'(MAX*MAX-1);
  localparam logic [PW-1:0] c_pair_one        = PW'(1);
  localparam logic [CW-1:0] c_hold_last       = CW'(HOLD-1);
  localparam logic [CW-1:0] c_settle_last     = CW'(SETTLE-1);
  localparam logic [CW-1:0] c_cnt_one         = CW'(1);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_LD_RE   = 4'd1,
    S_HOLD_HI = 4'd2,
    S_LD_IM   = 4'd3,
    S_HOLD_LO = 4'd4,
    S_SETTLE  = 4'd5,
    S_RD_HI   = 4'd6,
    S_EMIT_RE = 4'd7,
    S_RD_LO   = 4'd8,
    S_EMIT_IM = 4'd9,
    S_CKSUM   = 4'd10
  } state_t;

  state_t          state_q, state_d;
  logic [7:0]      load_temp_q, load_temp_d;
  logic            load_ready_q, load_ready_d;
  logic            new_gate_q, new_gate_d;
  logic [PW-1:0]   pair_q, pair_d;
  logic [7:0]      gates_left_q, gates_left_d;
  logic            phase_q, phase_d;          // 0: state vector, 1: gate blocks
  logic [CW-1:0]   cnt_q, cnt_d;              // shared HOLD / SETTLE counter
  logic [7:0]      tx_data_q, tx_data_d;
  logic            tx_valid_q, tx_valid_d;
  logic            busy_q, busy_d;
`ifdef QC_LINK_CHECKSUM_EN
  logic [7:0]      cksum_q, cksum_d;
`endif

  always_comb begin
    state_d      = state_q;
    load_temp_d  = load_temp_q;
    load_ready_d = load_ready_q;
    new_gate_d   = new_gate_q;
    pair_d       = pair_q;
    gates_left_d = gates_left_q;
    phase_d      = phase_q;
    cnt_d        = cnt_q;
    tx_data_d    = tx_data_q;
    tx_valid_d   = tx_valid_q;
    busy_d       = busy_q;
`ifdef QC_LINK_CHECKSUM_EN
    cksum_d      = cksum_q;
`endif

    case (state_q)
      S_IDLE: begin
        new_gate_d = 1'b0;
        if (rx_valid) begin
          // A header of zero still carries one gate block.
          gates_left_d = (rx_data == 8'd0) ? 8'd1 : rx_data;
          pair_d       = '0;
          phase_d      = 1'b0;
          cnt_d        = '0;
          busy_d       = 1'b1;
`ifdef QC_LINK_CHECKSUM_EN
          cksum_d      = 8'd0;
`endif
          state_d      = S_LD_RE;
        end
      end

      S_LD_RE: begin
        if (rx_valid) begin
          load_temp_d  = rx_data;
          load_ready_d = 1'b1;
          // The continuation flag changes only with the first real byte of
          // a gate so the partner sees it stable for the whole block.
          if (phase_q && (pair_q == '0)) begin
            new_gate_d = (gates_left_q > 8'd1);
          end
          cnt_d   = '0;
          state_d = S_HOLD_HI;
        end
      end

      S_HOLD_HI: begin
        if (cnt_q == c_hold_last) begin
          cnt_d   = '0;
          state_d = S_LD_IM;
        end else begin
          cnt_d = cnt_q + c_cnt_one;
        end
      end

      S_LD_IM: begin
        if (rx_valid) begin
          load_temp_d  = rx_data;
          load_ready_d = 1'b0;
          cnt_d        = '0;
          state_d      = S_HOLD_LO;
        end
      end

      S_HOLD_LO: begin
        if (cnt_q == c_hold_last) begin
          cnt_d   = '0;
          state_d = S_LD_RE;
          if (!phase_q) begin
            if (pair_q == c_pair_state_last) begin
              phase_d = 1'b1;
              pair_d  = '0;
            end else begin
              pair_d = pair_q + c_pair_one;
            end
          end else if (pair_q == c_pair_gate_last) begin
            pair_d       = '0;
            gates_left_d = gates_left_q - 8'd1;
            if (gates_left_q == 8'd1) begin
              state_d = S_SETTLE;
            end
          end else begin
            pair_d = pair_q + c_pair_one;
          end
        end else begin
          cnt_d = cnt_q + c_cnt_one;
        end
      end

      S_SETTLE: begin
        if (cnt_q == c_settle_last) begin
          cnt_d        = '0;
          pair_d       = '0;
          load_ready_d = 1'b1;   // first readout edge: read real
          state_d      = S_RD_HI;
        end else begin
          cnt_d = cnt_q + c_cnt_one;
        end
      end

      S_RD_HI: begin
        if (cnt_q == c_hold_last) begin
          cnt_d      = '0;
          tx_data_d  = send_temp;
          tx_valid_d = 1'b1;
`ifdef QC_LINK_CHECKSUM_EN
          cksum_d    = cksum_q ^ send_temp;
`endif
          state_d    = S_EMIT_RE;
        end else begin
          cnt_d = cnt_q + c_cnt_one;
        end
      end

      S_EMIT_RE: begin
        // load_ready stays high until the sink takes the byte.
        if (tx_ready) begin
          tx_valid_d   = 1'b0;
          load_ready_d = 1'b0;
          state_d      = S_RD_LO;
        end
      end

      S_RD_LO: begin
        if (cnt_q == c_hold_last) begin
          cnt_d      = '0;
          tx_data_d  = send_temp;
          tx_valid_d = 1'b1;
`ifdef QC_LINK_CHECKSUM_EN
          cksum_d    = cksum_q ^ send_temp;
`endif
          state_d    = S_EMIT_IM;
        end else begin
          cnt_d = cnt_q + c_cnt_one;
        end
      end

      S_EMIT_IM: begin
        if (tx_ready) begin
          tx_valid_d = 1'b0;
          if (pair_q == c_pair_state_last) begin
`ifdef QC_LINK_CHECKSUM_EN
            tx_data_d  = cksum_q;
            tx_valid_d = 1'b1;
            state_d    = S_CKSUM;
`else
            busy_d     = 1'b0;
            state_d    = S_IDLE;
`endif
          end else begin
            pair_d       = pair_q + c_pair_one;
            load_ready_d = 1'b1;
            state_d      = S_RD_HI;
          end
        end
      end

`ifdef QC_LINK_CHECKSUM_EN
      S_CKSUM: begin
        if (tx_ready) begin
          tx_valid_d = 1'b0;
          busy_d     = 1'b0;
          state_d    = S_IDLE;
        end
      end
`endif

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      load_temp_q  <= 8'd0;
      load_ready_q <= 1'b0;
      new_gate_q   <= 1'b0;
      pair_q       <= '0;
      gates_left_q <= 8'd0;
      phase_q      <= 1'b0;
      cnt_q        <= '0;
      tx_data_q    <= 8'd0;
      tx_valid_q   <= 1'b0;
      busy_q       <= 1'b0;
`ifdef QC_LINK_CHECKSUM_EN
      cksum_q      <= 8'd0;
`endif
    end else begin
      state_q      <= state_d;
      load_temp_q  <= load_temp_d;
      load_ready_q <= load_ready_d;
      new_gate_q   <= new_gate_d;
      pair_q       <= pair_d;
      gates_left_q <= gates_left_d;
      phase_q      <= phase_d;
      cnt_q        <= cnt_d;
      tx_data_q    <= tx_data_d;
      tx_valid_q   <= tx_valid_d;
      busy_q       <= busy_d;
`ifdef QC_LINK_CHECKSUM_EN
      cksum_q      <= cksum_d;
`endif
    end
  end

  // Gated by reset so the stream is held off during the reset cycle itself.
  assign rx_ready   = ~reset & ((state_q == S_IDLE) || (state_q == S_LD_RE) ||
                                (state_q == S_LD_IM));
  assign tx_data    = tx_data_q;
  assign tx_valid   = tx_valid_q;
  assign load_temp  = load_temp_q;
  assign load_ready = load_ready_q;
  assign new_gate   = {7'd0, new_gate_q};
  assign busy       = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_qc_link_master.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : tb_qc_link_master                                        |
// | Description : Directed self-checking bench for qc_link_master with a   |
// |               behavioural partner FSM that collects the loaded state   |
// |               and gates, applies them, and serves the readout.         |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module tb_qc_link_master;

  localparam int N      = 2;
  localparam int MAX    = 4;
  localparam int HOLD   = 4;
  localparam int SETTLE = 8;
`ifdef QC_LINK_CHECKSUM_EN
  localparam int NTX = 2*MAX + 1;
`else
  localparam int NTX = 2*MAX;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] load_temp;
  logic       load_ready;
  logic [7:0] new_gate;
  logic [7:0] send_temp;
  logic       busy;

  qc_link_master #(.N(N), .HOLD(HOLD), .SETTLE(SETTLE)) u_dut (
    .clk        (clk),
    .reset      (reset),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .load_temp  (load_temp),
    .load_ready (load_ready),
    .new_gate   (new_gate),
    .send_temp  (send_temp),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- partner FSM model and monitors ----------------
  logic signed [7:0] s_re [MAX];
  logic signed [7:0] s_im [MAX];
  logic signed [7:0] g_re [MAX*MAX];
  logic signed [7:0] g_im [MAX*MAX];
  logic [7:0] tx_q [$];
  bit         ng_first [$];
  bit         ng_last  [$];
  int   pcnt = 0, ridx = 0, cyc = 0, last_rise = -1, last_iv = 0;
  int   lr_viol = 0, stall_viol = 0, ng_hi_viol = 0;
  bit   in_gate = 0, rd_mode = 0, pending = 0;
  logic lr_prev = 1'b0, prev_rx_hs = 1'b0, prev_tx_stall = 1'b0;
  logic [7:0] cur_re = 8'd0, pend_val = 8'd0, prev_tx_data = 8'd0;

  task automatic apply_gate();
    int ar, ai;
    logic signed [7:0] nr [MAX];
    logic signed [7:0] ni [MAX];
    for (int r = 0; r < MAX; r++) begin
      ar = 0; ai = 0;
      for (int c = 0; c < MAX; c++) begin
        ar += int'(g_re[r*MAX+c]) * int'(s_re[c]) - int'(g_im[r*MAX+c]) * int'(s_im[c]);
        ai += int'(g_re[r*MAX+c]) * int'(s_im[c]) + int'(g_im[r*MAX+c]) * int'(s_re[c]);
      end
      nr[r] = ar[7:0];
      ni[r] = ai[7:0];
    end
    for (int r = 0; r < MAX; r++) begin
      s_re[r] = nr[r];
      s_im[r] = ni[r];
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      pcnt = 0; ridx = 0; in_gate = 0; rd_mode = 0; pending = 0;
      last_rise = -1; send_temp = 8'd0;
      lr_prev = 1'b0; prev_rx_hs = 1'b0; prev_tx_stall = 1'b0; prev_tx_data = 8'd0;
    end else begin
      if (pending) begin
        send_temp = pend_val;
        pending = 0;
      end
      if (new_gate[7:1] != 7'd0) ng_hi_viol++;
      if (prev_tx_stall && (!tx_valid || tx_data !== prev_tx_data)) stall_viol++;
      if (load_ready !== lr_prev) begin
        if (!rd_mode && !prev_rx_hs) lr_viol++;
        if (rd_mode && prev_tx_stall) lr_viol++;
        if (!rd_mode) begin
          if (load_ready) begin
            cur_re = load_temp;
            if (in_gate && pcnt == 0) ng_first.push_back(new_gate[0]);
            if (last_rise >= 0) last_iv = cyc - last_rise;
            last_rise = cyc;
          end else if (!in_gate) begin
            s_re[pcnt] = cur_re;
            s_im[pcnt] = load_temp;
            pcnt++;
            if (pcnt == MAX) begin in_gate = 1; pcnt = 0; end
          end else begin
            g_re[pcnt] = cur_re;
            g_im[pcnt] = load_temp;
            pcnt++;
            if (pcnt == MAX*MAX) begin
              ng_last.push_back(new_gate[0]);
              apply_gate();
              pcnt = 0;
              if (!new_gate[0]) begin rd_mode = 1; ridx = 0; end
            end
          end
        end else begin
          // Partner answers one cycle after it notices the edge.
          pending = 1;
          if (load_ready) pend_val = s_re[ridx];
          else begin
            pend_val = s_im[ridx];
            ridx++;
            if (ridx == MAX) begin
              rd_mode = 0; in_gate = 0; pcnt = 0; last_rise = -1;
            end
          end
        end
      end
      if (tx_valid && tx_ready) tx_q.push_back(tx_data);
      prev_rx_hs    = rx_valid && rx_ready;
      prev_tx_stall = tx_valid && !tx_ready;
      prev_tx_data  = tx_data;
      lr_prev       = load_ready;
    end
  end

  // ---------------- stimulus helpers ----------------
  logic [7:0] frame_q [$];
  int tb0 = 0, nf0 = 0, nl0 = 0, lv0 = 0, sv0 = 0;

  task automatic add_pair(input logic [7:0] re, input logic [7:0] im);
    frame_q.push_back(re);
    frame_q.push_back(im);
  endtask

  // MSB-first: re0, im0, re1, im1, ...
  task automatic add_state(input logic [63:0] v);
    for (int i = 0; i < 8; i++) frame_q.push_back(v[63-8*i -: 8]);
  endtask

  // xi=0: identity, xi=1: X (x) I, i.e. row r has its 1 in column r^2.
  task automatic add_gate(input bit xi);
    for (int r = 0; r < MAX; r++)
      for (int c = 0; c < MAX; c++)
        add_pair((c == (xi ? (r ^ 2) : r)) ? 8'd1 : 8'd0, 8'd0);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    repeat (gap) @(posedge clk);
    @(posedge clk); #1;
    rx_data  = b;
    rx_valid = 1'b1;
    t = 0;
    @(negedge clk);
    while (!rx_ready && t < 500) begin @(negedge clk); t++; end
    if (!rx_ready) chk("rx_timeout", {31'd0, rx_ready}, 32'd1);
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input int maxgap, input int count);
    int n;
    n = (count < 0) ? frame_q.size() : count;
    for (int i = 0; i < n; i++)
      send_byte(frame_q[i], (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0);
    frame_q.delete();
  endtask

  task automatic start_test();
    tb0 = tx_q.size(); nf0 = ng_first.size(); nl0 = ng_last.size();
    lv0 = lr_viol; sv0 = stall_viol;
  endtask

  task automatic wait_done(input int n);
    int t;
    t = 0;
    while ((tx_q.size() - tb0) < n && t < 20000) begin @(negedge clk); #1; t++; end
    if ((tx_q.size() - tb0) < n) chk("tx_timeout", tx_q.size() - tb0, n);
    else begin
      chk("busy_at_last_accept", {31'd0, busy}, 32'd1);
      @(negedge clk); #1;
      chk("busy_after_accept", {31'd0, busy}, 32'd0);
      chk("tx_valid_after", {31'd0, tx_valid}, 32'd0);
    end
    repeat (5) @(negedge clk);
  endtask

  task automatic check_tx(input string name, input logic [63:0] exp);
    logic [31:0] g;
    chk({name, "_count"}, tx_q.size() - tb0, NTX);
    for (int i = 0; i < 8; i++) begin
      if (tb0 + i < tx_q.size()) g = {24'd0, tx_q[tb0+i]};
      else g = 'x;
      chk($sformatf("%s_tx%0d", name, i), g, {24'd0, exp[63-8*i -: 8]});
    end
    chk({name, "_lr_viol"}, lr_viol - lv0, 0);
  endtask

  task automatic check_ng(input string name, input int idx, input bit f, input bit l);
    logic [31:0] gf, gl;
    gf = (nf0 + idx < ng_first.size()) ? {31'd0, ng_first[nf0+idx]} : 'x;
    gl = (nl0 + idx < ng_last.size())  ? {31'd0, ng_last[nl0+idx]}  : 'x;
    chk($sformatf("%s_ng_first%0d", name, idx), gf, {31'd0, f});
    chk($sformatf("%s_ng_last%0d", name, idx), gl, {31'd0, l});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    reset = 1'b1; rx_valid = 1'b0; rx_data = 8'd0; tx_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_load_temp",  {24'd0, load_temp}, 32'd0);
    chk("rst_load_ready", {31'd0, load_ready}, 32'd0);
    chk("rst_new_gate",   {24'd0, new_gate}, 32'd0);
    chk("rst_rx_ready",   {31'd0, rx_ready}, 32'd0);
    chk("rst_tx_valid",   {31'd0, tx_valid}, 32'd0);
    chk("rst_tx_data",    {24'd0, tx_data}, 32'd0);
    chk("rst_busy",       {31'd0, busy}, 32'd0);
    @(posedge clk); #1; reset = 1'b0;
    @(negedge clk);
    chk("idle_rx_ready", {31'd0, rx_ready}, 32'd1);

    // T1: G=1, basis state |0>, identity gate.
    start_test();
    frame_q.push_back(8'd1);
    add_state(64'h01_00_00_00_00_00_00_00);
    add_gate(0);
    chk("t1_frame_len", frame_q.size(), 41);
    send_frame(0, -1);
    chk("t1_busy_loading", {31'd0, busy}, 32'd1);
    wait_done(NTX);
    check_tx("t1", 64'h01_00_00_00_00_00_00_00);
    check_ng("t1", 0, 1'b0, 1'b0);
    chk("t1_pair_cycles", last_iv, 2 + 2*HOLD);

    // T2: G=2, X(x)I twice returns (5,1) to index 0.
    start_test();
    frame_q.push_back(8'd2);
    add_state(64'h05_01_00_00_00_00_00_00);
    add_gate(1); add_gate(1);
    send_frame(0, -1);
    wait_done(NTX);
    check_tx("t2", 64'h05_01_00_00_00_00_00_00);
    check_ng("t2", 0, 1'b1, 1'b1);
    check_ng("t2", 1, 1'b0, 1'b0);

    // T3: same frame with random rx gaps and a 20-cycle tx stall.
    start_test();
    frame_q.push_back(8'd2);
    add_state(64'h05_01_00_00_00_00_00_00);
    add_gate(1); add_gate(1);
    send_frame(10, -1);
    t = 0;
    while ((tx_q.size() - tb0) < 3 && t < 5000) begin @(negedge clk); #1; t++; end
    if ((tx_q.size() - tb0) < 3) chk("t3_stall_wait", tx_q.size() - tb0, 3);
    @(posedge clk); #1; tx_ready = 1'b0;
    repeat (20) @(posedge clk);
    #1; tx_ready = 1'b1;
    wait_done(NTX);
    check_tx("t3", 64'h05_01_00_00_00_00_00_00);
    chk("t3_stall_viol", stall_viol - sv0, 0);

    // T4: reset during gate pair 7 of a G=2 frame, then a fresh frame.
    frame_q.push_back(8'd2);
    add_state(64'h01_02_03_04_05_06_07_08);
    add_gate(1); add_gate(1);
    send_frame(0, 24);
    repeat (2) @(negedge clk);
    chk("t4_pre_new_gate", {24'd0, new_gate}, 32'd1);
    chk("t4_pre_load_temp", {24'd0, load_temp}, 32'd1);
    @(posedge clk); #1; reset = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("t4_rst_load_temp",  {24'd0, load_temp}, 32'd0);
    chk("t4_rst_load_ready", {31'd0, load_ready}, 32'd0);
    chk("t4_rst_new_gate",   {24'd0, new_gate}, 32'd0);
    chk("t4_rst_rx_ready",   {31'd0, rx_ready}, 32'd0);
    chk("t4_rst_tx_valid",   {31'd0, tx_valid}, 32'd0);
    chk("t4_rst_busy",       {31'd0, busy}, 32'd0);
    @(posedge clk); #1; reset = 1'b0;
    @(negedge clk);
    chk("t4_idle_rx_ready", {31'd0, rx_ready}, 32'd1);
    start_test();
    frame_q.push_back(8'd1);
    add_state(64'h01_02_03_04_05_06_07_08);
    add_gate(1);
    send_frame(0, -1);
    wait_done(NTX);
    check_tx("t4", 64'h05_06_07_08_01_02_03_04);
    check_ng("t4", 0, 1'b0, 1'b0);

    // T5: header 0 behaves as one gate.
    start_test();
    frame_q.push_back(8'd0);
    add_state(64'h00_00_FF_02_00_00_00_00);
    add_gate(0);
    send_frame(0, -1);
    wait_done(NTX);
    check_tx("t5", 64'h00_00_FF_02_00_00_00_00);
    check_ng("t5", 0, 1'b0, 1'b0);

`ifdef QC_LINK_CHECKSUM_EN
    // T6: readout 10,20,30,40,0,0,0,0 -> checksum 40 (0x28).
    start_test();
    frame_q.push_back(8'd1);
    add_state(64'h0A_14_1E_28_00_00_00_00);
    add_gate(0);
    send_frame(0, -1);
    wait_done(NTX);
    check_tx("t6", 64'h0A_14_1E_28_00_00_00_00);
    chk("t6_cksum", (tb0 + 8 < tx_q.size()) ? {24'd0, tx_q[tb0+8]} : 32'hx, 32'h28);
`endif

    chk("new_gate_upper_bits", ng_hi_viol, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
